// File: rtl/branch_redirect_ctrl_if.sv
// branch_redirect_ctrl_if: execute-side redirect request and PC/fetch control bundle
// master drives the branch decision and pipeline status, slave is the redirect sequencer.
interface branch_redirect_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             ex_valid;
  logic             br_taken;
  logic [31:0]      br_target;
  logic             stall_in;
  logic             imem_ready;
  logic             pc_load;
  logic [31:0]      redirect_pc;
  logic             flush_if;
  logic             ex_kill;
  logic             busy;
  logic [CNT_W-1:0] redirect_count;
  modport master (
    output ex_valid, br_taken, br_target, stall_in, imem_ready,
    input  pc_load, redirect_pc, flush_if, ex_kill, busy, redirect_count
  );
  modport slave (
    input  ex_valid, br_taken, br_target, stall_in, imem_ready,
    output pc_load, redirect_pc, flush_if, ex_kill, busy, redirect_count
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns an accepted taken branch into PC load, fetch flush and execute kill
// All outputs are Moore decodes of the registered state, target and counter.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_redirect_ctrl_if.slave br
);
  typedef enum logic [1:0] {IDLE, HOLD, REDIRECT, DRAIN} state_t;
  localparam logic [2:0] DRAIN_INIT = 3'(FLUSH_CYCLES - 1);
  state_t           state_q, state_d;
  logic [31:0]      target_q, target_d;
  logic [2:0]       drain_q, drain_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  // Branch inputs outside IDLE belong to wrong-path instructions and are ignored.
  assign accept = state_q == IDLE && br.ex_valid && br.br_taken;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      drain_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      drain_q  <= drain_d;
      count_q  <= count_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    target_d = accept ? {br.br_target[31:1], 1'b0} : target_q;
    drain_d  = drain_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = br.stall_in ? HOLD : REDIRECT;
      HOLD:     if (!br.stall_in) state_d = REDIRECT;
      REDIRECT: if (br.imem_ready) begin
        count_d = &count_q ? count_q : count_q + 1'b1;
        drain_d = DRAIN_INIT;
        state_d = FLUSH_CYCLES == 1 ? IDLE : DRAIN;
      end
      DRAIN:    if (!br.stall_in) begin
        drain_d = drain_q - 1'b1;
        state_d = drain_q == 3'd1 ? IDLE : DRAIN;
      end
      default:  state_d = IDLE;
    endcase
  end
  assign br.pc_load        = state_q == REDIRECT;
  assign br.flush_if       = state_q != IDLE;
  assign br.ex_kill        = state_q != IDLE;
  assign br.busy           = state_q != IDLE;
  assign br.redirect_pc    = target_q;
  assign br.redirect_count = count_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: table vectors, directed corners and random traffic against a reference model
module tb_branch_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, ex_valid, br_taken, stall_in, imem_ready;
  logic [31:0] br_target;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  branch_redirect_ctrl_if #(.CNT_W(2))  a_if ();
  branch_redirect_ctrl_if #(.CNT_W(16)) b_if ();
  assign a_if.ex_valid   = ex_valid;
  assign a_if.br_taken   = br_taken;
  assign a_if.br_target  = br_target;
  assign a_if.stall_in   = stall_in;
  assign a_if.imem_ready = imem_ready;
  assign b_if.ex_valid   = ex_valid;
  assign b_if.br_taken   = br_taken;
  assign b_if.br_target  = br_target;
  assign b_if.stall_in   = stall_in;
  assign b_if.imem_ready = imem_ready;
  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2))  dut_a (.clk(clk), .rst_n(rst_n), .br(a_if.slave));
  branch_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .br(b_if.slave));
  typedef struct {
    bit          active;
    bit          wait_stall;
    bit          loading;
    int          flush_left;
    logic [31:0] tgt;
    int          cnt;
  } mdl_t;
  mdl_t ma, mb;
  function automatic mdl_t step(mdl_t m, int f, int w, logic rn, logic ev, logic bt,
                                logic [31:0] tg, logic st, logic rd);
    mdl_t n = m;
    int   max = (1 << w) - 1;
    if (!rn) begin
      n = '{default: 0};
    end else if (!m.active) begin
      if (ev && bt) begin
        n.active     = 1;
        n.tgt        = tg & 32'hFFFF_FFFE;
        n.wait_stall = st;
        n.loading    = !st;
      end
    end else if (m.wait_stall) begin
      if (!st) begin
        n.wait_stall = 0;
        n.loading    = 1;
      end
    end else if (m.loading) begin
      if (rd) begin
        n.cnt        = m.cnt < max ? m.cnt + 1 : max;
        n.loading    = 0;
        n.flush_left = f - 1;
        n.active     = f > 1;
      end
    end else if (!st) begin
      n.flush_left = m.flush_left - 1;
      n.active     = n.flush_left > 0;
    end
    return n;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_model();
    chk("a.pc_load", 32'(a_if.pc_load), 32'(ma.loading));
    chk("a.flush_if", 32'(a_if.flush_if), 32'(ma.active));
    chk("a.ex_kill", 32'(a_if.ex_kill), 32'(ma.active));
    chk("a.busy", 32'(a_if.busy), 32'(ma.active));
    chk("a.redirect_pc", a_if.redirect_pc, ma.tgt);
    chk("a.redirect_count", 32'(a_if.redirect_count), 32'(ma.cnt));
    chk("b.pc_load", 32'(b_if.pc_load), 32'(mb.loading));
    chk("b.flush_if", 32'(b_if.flush_if), 32'(mb.active));
    chk("b.ex_kill", 32'(b_if.ex_kill), 32'(mb.active));
    chk("b.busy", 32'(b_if.busy), 32'(mb.active));
    chk("b.redirect_pc", b_if.redirect_pc, mb.tgt);
    chk("b.redirect_count", 32'(b_if.redirect_count), 32'(mb.cnt));
  endtask
  task automatic cycle(input logic rn, input logic ev, input logic bt, input logic [31:0] tg,
                       input logic st, input logic rd);
    rst_n = rn; ex_valid = ev; br_taken = bt; br_target = tg; stall_in = st; imem_ready = rd;
    ma = step(ma, 2, 2, rn, ev, bt, tg, st, rd);
    mb = step(mb, 3, 16, rn, ev, bt, tg, st, rd);
    @(posedge clk);
    #1;
    chk_model();
  endtask
  typedef struct {
    logic        rn, ev, bt;
    logic [31:0] tg;
    logic        st, rd;
    logic        pc, fl, bs;
    logic [31:0] rpc;
    logic [1:0]  cnt;
  } vec_t;
  vec_t tbl[$];
  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    tbl.push_back('{0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 32'h0,    2'd0});
    tbl.push_back('{1, 1, 0, 32'h1235, 0, 1, 0, 0, 0, 32'h0,    2'd0});
    tbl.push_back('{1, 1, 1, 32'h1235, 0, 1, 1, 1, 1, 32'h1234, 2'd0});
    tbl.push_back('{1, 0, 0, 32'h0,    0, 1, 0, 1, 1, 32'h1234, 2'd1});
    tbl.push_back('{1, 0, 0, 32'h0,    0, 1, 0, 0, 0, 32'h1234, 2'd1});
    tbl.push_back('{1, 1, 1, 32'h81,   1, 1, 0, 1, 1, 32'h80,   2'd1});
    tbl.push_back('{1, 1, 1, 32'h99,   1, 1, 0, 1, 1, 32'h80,   2'd1});
    tbl.push_back('{1, 0, 0, 32'h0,    1, 1, 0, 1, 1, 32'h80,   2'd1});
    tbl.push_back('{1, 0, 0, 32'h0,    0, 0, 1, 1, 1, 32'h80,   2'd1});
    tbl.push_back('{1, 0, 0, 32'h0,    0, 0, 1, 1, 1, 32'h80,   2'd1});
    tbl.push_back('{1, 0, 0, 32'h0,    1, 0, 1, 1, 1, 32'h80,   2'd1});
    tbl.push_back('{1, 1, 1, 32'h44,   0, 0, 1, 1, 1, 32'h80,   2'd1});
    tbl.push_back('{1, 0, 0, 32'h0,    0, 0, 1, 1, 1, 32'h80,   2'd1});
    tbl.push_back('{1, 0, 0, 32'h0,    0, 1, 0, 1, 1, 32'h80,   2'd2});
    tbl.push_back('{1, 1, 1, 32'h5555, 1, 1, 0, 1, 1, 32'h80,   2'd2});
    tbl.push_back('{1, 1, 1, 32'h5555, 0, 1, 0, 0, 0, 32'h80,   2'd2});
    tbl.push_back('{1, 1, 1, 32'h101,  0, 0, 1, 1, 1, 32'h100,  2'd2});
    tbl.push_back('{0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 32'h0,    2'd0});
    tbl.push_back('{1, 0, 0, 32'h0,    0, 1, 0, 0, 0, 32'h0,    2'd0});
    foreach (tbl[i]) begin
      cycle(tbl[i].rn, tbl[i].ev, tbl[i].bt, tbl[i].tg, tbl[i].st, tbl[i].rd);
      chk($sformatf("vec%0d.pc_load", i), 32'(a_if.pc_load), 32'(tbl[i].pc));
      chk($sformatf("vec%0d.flush_if", i), 32'(a_if.flush_if), 32'(tbl[i].fl));
      chk($sformatf("vec%0d.ex_kill", i), 32'(a_if.ex_kill), 32'(tbl[i].fl));
      chk($sformatf("vec%0d.busy", i), 32'(a_if.busy), 32'(tbl[i].bs));
      chk($sformatf("vec%0d.redirect_pc", i), a_if.redirect_pc, tbl[i].rpc);
      chk($sformatf("vec%0d.count", i), 32'(a_if.redirect_count), 32'(tbl[i].cnt));
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0, 32'hDEAD_BEEF, i[0], 1);
      chk("idle.outputs", {28'h0, a_if.pc_load, a_if.flush_if, a_if.ex_kill, a_if.busy}, 32'h0);
      chk("idle.count", 32'(a_if.redirect_count), 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 1, 32'h200 + 32'(i), 0, 1);
      cycle(1, 0, 0, 32'h0, 0, 1);
      cycle(1, 0, 0, 32'h0, 0, 1);
      chk("sat.idle", 32'(a_if.busy), 32'h0);
      chk("sat.count", 32'(a_if.redirect_count), i < 3 ? 32'(i + 1) : 32'd3);
    end
    cycle(1, 0, 0, 32'h0, 0, 1);
    cycle(1, 1, 1, 32'h301, 0, 0);
    cycle(1, 0, 0, 32'h0, 0, 0);
    rst_n = 0;
    ma = '{default: 0};
    mb = '{default: 0};
    @(posedge clk);
    #1;
    chk("midreset.busy", 32'(a_if.busy), 32'h0);
    chk("midreset.pc_load", 32'(a_if.pc_load), 32'h0);
    chk("midreset.redirect_pc", a_if.redirect_pc, 32'h0);
    chk_model();
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 200) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0, $urandom,
            ($urandom % 4) == 0, ($urandom % 3) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences the control-flow redirect of the three-stage pipeline. It takes the branch unit's taken decision and target from the execute stage and turns each accepted redirect into a registered multi-cycle sequence: PC load, fetch-side flush and execute-side kill. The sequence tolerates pipeline stalls and instruction-memory back-pressure. It sits between the branch unit / ALU target path and the PC register, IF/EX pipeline register and instruction-memory request logic.

## Interface

Parameters:
- FLUSH_CYCLES, 1, flush cycles after PC load is accepted (legal 1..7)
- CNT_W, 16, width of the redirect performance counter

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  execute stage holds a valid (non-bubble) instruction
- br_taken  in  1  branch unit decision (conditional branch taken, JAL, JALR)
- br_target  in  32  target address computed in execute
- stall_in  in  1  pipeline stall (hazard / data-memory busy)
- imem_ready  in  1  instruction memory accepts a new fetch address this cycle
- pc_load  out  1  PC register loads redirect_pc this cycle
- redirect_pc  out  32  redirect target, bit 0 forced to 0
- flush_if  out  1  clear IF/EX pipeline register to bubble
- ex_kill  out  1  treat current execute instruction as bubble (no writeback, no branch)
- busy  out  1  state != IDLE
- redirect_count  out  CNT_W  saturating count of completed PC loads

## Operation

- States: IDLE, HOLD, REDIRECT, DRAIN. All outputs are Moore decodes of registered state, target register and counter.
- Accept condition: state==IDLE && ex_valid && br_taken. On acceptance, the target register captures {br_target[31:1],1'b0}.
- IDLE, accept, stall_in=0 → REDIRECT. IDLE, accept, stall_in=1 → HOLD. Otherwise stay IDLE.
- HOLD: flush_if=1, ex_kill=1. If stall_in=0, go to REDIRECT; else stay in HOLD.
- REDIRECT: pc_load=1, flush_if=1, ex_kill=1, redirect_pc=target register. If imem_ready=1:
  - redirect_count increments, saturating at all-ones;
  - if FLUSH_CYCLES==1, go to IDLE; else go to DRAIN with drain counter = FLUSH_CYCLES-1.
- If imem_ready=0 in REDIRECT, stay in REDIRECT with pc_load and redirect_pc held stable.
- DRAIN: flush_if=1, ex_kill=1, pc_load=0.
  - The drain counter decrements only when stall_in=0.
  - When it decrements from 1 to 0 (stall_in=0), go to IDLE.
- In IDLE, pc_load=0, flush_if=0 and ex_kill=0.
- br_taken/ex_valid are ignored outside IDLE, because wrong-path instructions are killed and never start a new redirect.
- stall_in has no effect in REDIRECT; only imem_ready gates the PC load.
- redirect_pc always shows the target register, whose value is meaningful only while pc_load=1.
- busy=1 in HOLD, REDIRECT and DRAIN.

## Timing

- Reset (rst_n=0 at a clock edge):
  - state=IDLE, target register=0, drain counter=0, redirect_count=0;
  - hence pc_load=0, flush_if=0, ex_kill=0, busy=0, redirect_pc=0.
- Reset takes priority over every other input, including a sequence in progress.
- Latency: if a redirect is accepted in cycle N with stall_in=0, pc_load=1 in cycle N+1. With imem_ready=1 in N+1, flush_if/ex_kill span cycles N+1..N+FLUSH_CYCLES, and busy drops in N+FLUSH_CYCLES+1.
- Each HOLD cycle (stall_in=1 at acceptance or while held) adds one cycle before REDIRECT. Each imem_ready=0 cycle in REDIRECT adds one cycle.
- The earliest next acceptance is the first cycle back in IDLE, so back-to-back redirects are separated by at least FLUSH_CYCLES+1 cycles.
- redirect_count updates on the edge ending the REDIRECT cycle in which imem_ready=1. At all-ones it stays all-ones.

## Test plan

- Reset then idle: after rst_n low then high, with ex_valid=1 and br_taken=0 → all outputs 0 and redirect_count=0 for 10 cycles.
- Basic redirect, FLUSH_CYCLES=2: accept at cycle N with br_target=0x0000_1235, stall_in=0, imem_ready=1 →
  - N+1: pc_load=1, redirect_pc=0x0000_1234, flush_if=1;
  - N+2: flush_if=1, pc_load=0;
  - N+3: IDLE, redirect_count=1.
- Stall at acceptance: accept with stall_in=1 held for 3 cycles → HOLD for 3 cycles (flush_if=1, pc_load=0), then pc_load=1 the cycle after stall_in falls.
- Back-pressure: imem_ready=0 for 4 cycles in REDIRECT → pc_load=1 and redirect_pc stable for 5 cycles. The count increments once, on the cycle imem_ready=1.
- Wrong-path ignore and mid-sequence reset:
  - br_taken=1 with a different target during DRAIN → no new pc_load, target unchanged;
  - rst_n=0 in REDIRECT → the next cycle shows IDLE with all outputs 0.
- Saturation, CNT_W=2: 5 completed redirects → redirect_count reads 1,2,3,3,3.
